// File: rtl/phj_pkg.sv
// Shared types and helpers for the partition hash-join datapath.
// Latency: n/a (types and pure functions). Backpressure: n/a.
// Used by the partition packers and the distributor checker.
package phj_pkg;

    localparam int TAG_WIDTH = 32;
    localparam int PART_BITS = 3;

    typedef enum logic [1:0] {
        FILL,
        EMIT,
        DONE
    } packer_state_t;

    // Partition id carried in the tag, MSB at decision_bit.
    function automatic logic [PART_BITS-1:0] tag_partition(
        input logic [TAG_WIDTH-1:0] tag,
        input int                   decision_bit
    );
        logic [TAG_WIDTH-1:0] shifted;
        shifted = tag >> (decision_bit - PART_BITS + 1);
        return shifted[PART_BITS-1:0];
    endfunction

endpackage

// File: rtl/pp_line_buffer.sv
// Slot register array that assembles one memory line, with per-slot fill mask.
// Latency: a write is visible on line/slot_mask the next cycle.
// Backpressure: none; the owner only writes while it holds in_ready.
module pp_line_buffer #(
    parameter  int INPUT_SIZE      = 64,
    parameter  int TUPLES_PER_LINE = 8,
    localparam int SLOT_W          = $clog2(TUPLES_PER_LINE)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  wr_en,
    input  logic [INPUT_SIZE-1:0]                 wr_dat,
    input  logic                                  clear,
    output logic [INPUT_SIZE*TUPLES_PER_LINE-1:0] line,
    output logic [TUPLES_PER_LINE-1:0]            slot_mask,
    output logic [SLOT_W-1:0]                     slot
);

    // Clearing the data too keeps unused slots of a partial line at zero.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            line      <= '0;
            slot_mask <= '0;
            slot      <= '0;
        end else if (wr_en) begin
            line[slot*INPUT_SIZE +: INPUT_SIZE] <= wr_dat;
            slot_mask[slot]                     <= 1'b1;
            slot                                <= slot + SLOT_W'(1);
        end
    end

endmodule

// File: rtl/partition_packer.sv
// Packs one partition's tuples into memory lines and issues line write requests.
// Latency: 1 cycle from the accept that fills a line to out_valid.
// Backpressure: in_ready low while a line waits for out_ready, after a flush, or when the region is full.
module partition_packer
    import phj_pkg::*;
#(
    parameter int                    INPUT_SIZE      = 64,
    parameter int                    TUPLES_PER_LINE = 8,
    parameter int                    DECISION_BIT    = 31,
    parameter int                    PARTITION_ID    = 0,
    parameter int                    ADDR_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter int                    PART_LINES      = 1024,
    localparam int LINE_W     = INPUT_SIZE*TUPLES_PER_LINE,
    localparam int LINE_BYTES = LINE_W/8,
    localparam int SLOT_BYTES = INPUT_SIZE/8,
    localparam int SLOT_W     = $clog2(TUPLES_PER_LINE),
    localparam int CNT_W      = $clog2(PART_LINES+1)
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  in_ready,
    input  logic [INPUT_SIZE-1:0] in,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    input  logic                  in_valid,
    input  logic                  flush,
    output logic                  flush_done,
    input  logic                  out_ready,
    output logic [LINE_W-1:0]     out_line,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [LINE_BYTES-1:0] out_mask,
    output logic                  out_last,
    output logic                  out_valid,
    output logic [CNT_W-1:0]      line_count,
    output logic                  overflow,
    output logic                  misroute
);

    packer_state_t state, state_n;
    logic          last_q, last_n;
    logic          flush_pend, flush_pend_n;
    logic          misroute_q;
    logic [CNT_W-1:0] line_idx;

    logic                       accept, full, flush_eff, emit_hs;
    logic [LINE_W-1:0]          buf_line;
    logic [TUPLES_PER_LINE-1:0] slot_mask;
    logic [SLOT_W-1:0]          slot;
    logic [LINE_BYTES-1:0]      byte_mask;
    logic [ADDR_WIDTH-1:0]      line_addr;

    assign full      = (line_idx == CNT_W'(PART_LINES));
    assign in_ready  = (state == FILL) && !flush_pend && !full;
    assign accept    = in_valid && in_ready;
    assign flush_eff = flush || flush_pend;
    assign emit_hs   = (state == EMIT) && out_ready;

    pp_line_buffer #(
        .INPUT_SIZE      (INPUT_SIZE),
        .TUPLES_PER_LINE (TUPLES_PER_LINE)
    ) u_line_buffer (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (accept),
        .wr_dat    (in),
        .clear     (emit_hs),
        .line      (buf_line),
        .slot_mask (slot_mask),
        .slot      (slot)
    );

    always_comb begin
        state_n      = state;
        last_n       = last_q;
        flush_pend_n = flush_pend || flush;
        case (state)
            FILL: begin
                if (full && flush_eff) begin
                    state_n      = DONE;
                    flush_pend_n = 1'b0;
                end else if (flush_eff) begin
                    // A tuple accepted alongside the flush lands in this line.
                    state_n      = EMIT;
                    last_n       = 1'b1;
                    flush_pend_n = 1'b0;
                end else if (accept && slot == SLOT_W'(TUPLES_PER_LINE-1)) begin
                    state_n = EMIT;
                    last_n  = 1'b0;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    state_n = last_q ? DONE : FILL;
                end
            end
            DONE: begin
                state_n = FILL;
            end
            default: begin
                state_n = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FILL;
            last_q     <= 1'b0;
            flush_pend <= 1'b0;
            misroute_q <= 1'b0;
            line_idx   <= '0;
        end else begin
            state      <= state_n;
            last_q     <= last_n;
            flush_pend <= flush_pend_n;
            if (accept && tag_partition(in_tag, DECISION_BIT) != PART_BITS'(PARTITION_ID)) begin
                misroute_q <= 1'b1;
            end
            if (emit_hs) begin
                line_idx <= line_idx + CNT_W'(1);
            end
        end
    end

    always_comb begin
        byte_mask = '0;
        for (int k = 0; k < TUPLES_PER_LINE; k++) begin
            byte_mask[k*SLOT_BYTES +: SLOT_BYTES] = {SLOT_BYTES{slot_mask[k]}};
        end
    end

    assign line_addr  = BASE_ADDR + ADDR_WIDTH'(line_idx) * ADDR_WIDTH'(LINE_BYTES);

    // Request fields read as zero whenever no line is being offered.
    assign out_valid  = (state == EMIT);
    assign out_last   = out_valid && last_q;
    assign out_line   = out_valid ? buf_line  : '0;
    assign out_mask   = out_valid ? byte_mask : '0;
    assign out_addr   = out_valid ? line_addr : '0;
    assign flush_done = (state == DONE);
    assign line_count = line_idx;
    assign overflow   = full;
    assign misroute   = misroute_q;

endmodule

// File: tb/tb_partition_packer.sv
// Directed self-checking bench for partition_packer: a default-sized instance
// and a two-line instance for the region-full behaviour.
module tb_partition_packer;

    localparam int LW = 512;
    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam logic [31:0] BASE2 = 32'h0000_2000;

    logic          clk;
    logic          reset;
    logic [63:0]   in;
    logic [31:0]   in_tag;
    logic          in_valid, in_ready, flush, flush_done, out_ready;
    logic [LW-1:0] out_line;
    logic [31:0]   out_addr;
    logic [63:0]   out_mask;
    logic          out_last, out_valid, overflow, misroute;
    logic [10:0]   line_count;

    logic          in_valid2, in_ready2, flush2, flush_done2, out_ready2;
    logic [LW-1:0] out_line2;
    logic [31:0]   out_addr2;
    logic [63:0]   out_mask2;
    logic          out_last2, out_valid2, overflow2, misroute2;
    logic [1:0]    line_count2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [LW-1:0] cap_line[$];
    logic [31:0]   cap_addr[$];
    logic [63:0]   cap_mask[$];
    logic          cap_last[$];
    int n_done, n_acc2, n_lines2, n_done2;

    partition_packer #(
        .BASE_ADDR (BASE)
    ) dut (
        .clk (clk), .reset (reset), .in_ready (in_ready), .in (in), .in_tag (in_tag),
        .in_valid (in_valid), .flush (flush), .flush_done (flush_done), .out_ready (out_ready),
        .out_line (out_line), .out_addr (out_addr), .out_mask (out_mask), .out_last (out_last),
        .out_valid (out_valid), .line_count (line_count), .overflow (overflow), .misroute (misroute)
    );

    partition_packer #(
        .BASE_ADDR  (BASE2),
        .PART_LINES (2)
    ) dut_small (
        .clk (clk), .reset (reset), .in_ready (in_ready2), .in (in), .in_tag (in_tag),
        .in_valid (in_valid2), .flush (flush2), .flush_done (flush_done2), .out_ready (out_ready2),
        .out_line (out_line2), .out_addr (out_addr2), .out_mask (out_mask2), .out_last (out_last2),
        .out_valid (out_valid2), .line_count (line_count2), .overflow (overflow2), .misroute (misroute2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshakes are recorded mid-cycle, ahead of the edge that completes them.
    always @(negedge clk) begin
        if (reset) begin
            cap_line.delete(); cap_addr.delete(); cap_mask.delete(); cap_last.delete();
            n_done = 0; n_acc2 = 0; n_lines2 = 0; n_done2 = 0;
        end else begin
            if (out_valid && out_ready) begin
                cap_line.push_back(out_line); cap_addr.push_back(out_addr);
                cap_mask.push_back(out_mask); cap_last.push_back(out_last);
            end
            if (flush_done)              n_done++;
            if (in_valid2 && in_ready2)  n_acc2++;
            if (out_valid2 && out_ready2) n_lines2++;
            if (flush_done2)             n_done2++;
        end
    end

    task automatic check_eq(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; in_valid2 = 1'b0; flush2 = 1'b0;
        out_ready = 1'b1; out_ready2 = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic send(input logic [63:0] d, input logic [31:0] t);
        int guard;
        guard = 0;
        in = d; in_tag = t; in_valid = 1'b1;
        while (!in_ready && guard < 100) begin
            tick(1);
            guard++;
        end
        if (guard == 100) check_eq("send_timeout", in_ready, 1);
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic send_run(input logic [63:0] first, input int n);
        for (int i = 0; i < n; i++) send(first + 64'(i), 32'h0000_0000);
    endtask

    function automatic logic [LW-1:0] mk_line(input logic [63:0] first, input int n);
        logic [LW-1:0] l;
        l = '0;
        for (int k = 0; k < n; k++) l[k*64 +: 64] = first + 64'(k);
        return l;
    endfunction

    function automatic logic [63:0] mk_mask(input int n);
        logic [63:0] m;
        m = '0;
        for (int k = 0; k < n; k++) m[k*8 +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic check_line(input string pfx, input int idx, input logic [LW-1:0] el,
                              input logic [31:0] ea, input logic [63:0] em, input logic elast);
        if (cap_line.size() > idx) begin
            check_eq({pfx, "_line"}, cap_line[idx], el);
            check_eq({pfx, "_addr"}, cap_addr[idx], ea);
            check_eq({pfx, "_mask"}, cap_mask[idx], em);
            check_eq({pfx, "_last"}, cap_last[idx], elast);
        end else begin
            check_eq({pfx, "_present"}, cap_line.size(), idx + 1);
        end
    endtask

    logic [LW-1:0] exp_line;

    initial begin
        in = '0; in_tag = '0;
        do_reset();

        // Reset state.
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_addr", out_addr, 0);
        check_eq("rst_line_count", line_count, 0);
        check_eq("rst_flags", {overflow, misroute, flush_done, out_last}, 0);

        // T1: one full line.
        send_run(64'h1, 8);
        tick(4);
        check_eq("t1_nlines", cap_line.size(), 1);
        check_line("t1_l0", 0, mk_line(64'h1, 8), BASE, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        check_eq("t1_line_count", line_count, 1);

        // T2: 20 tuples then flush.
        do_reset();
        send_run(64'h100, 20);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(6);
        check_eq("t2_nlines", cap_line.size(), 3);
        check_line("t2_l0", 0, mk_line(64'h100, 8), BASE, mk_mask(8), 1'b0);
        check_line("t2_l1", 1, mk_line(64'h108, 8), BASE + 32'd64, mk_mask(8), 1'b0);
        check_line("t2_l2", 2, mk_line(64'h110, 4), BASE + 32'd128, 64'h0000_0000_FFFF_FFFF, 1'b1);
        check_eq("t2_flush_done", n_done, 1);
        check_eq("t2_line_count", line_count, 3);
        check_eq("t2_ready_after", in_ready, 1);

        // T7: flush while a full line is pending gives a trailing empty line.
        do_reset();
        send_run(64'h600, 8);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(6);
        check_eq("t7_nlines", cap_line.size(), 2);
        check_line("t7_l0", 0, mk_line(64'h600, 8), BASE, mk_mask(8), 1'b0);
        check_line("t7_l1", 1, '0, BASE + 32'd64, 64'h0, 1'b1);
        check_eq("t7_flush_done", n_done, 1);

        // T3: stalled writer holds the line steady and blocks input.
        do_reset();
        out_ready = 1'b0;
        send_run(64'h200, 8);
        in = 64'h208; in_tag = '0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check_eq("t3_out_valid", out_valid, 1);
            check_eq("t3_in_ready", in_ready, 0);
            check_eq("t3_out_line", out_line, mk_line(64'h200, 8));
            check_eq("t3_out_addr", out_addr, BASE);
            tick(1);
        end
        out_ready = 1'b1;
        send_run(64'h208, 8);
        tick(4);
        check_eq("t3_nlines", cap_line.size(), 2);
        check_line("t3_l0", 0, mk_line(64'h200, 8), BASE, mk_mask(8), 1'b0);
        check_line("t3_l1", 1, mk_line(64'h208, 8), BASE + 32'd64, mk_mask(8), 1'b0);

        // T4: two-line region fills and then refuses input.
        do_reset();
        check_eq("t4_ovf_rst", overflow2, 0);
        in_valid2 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            in = 64'h300 + 64'(n_acc2);
            tick(1);
        end
        in_valid2 = 1'b0;
        check_eq("t4_accepted", n_acc2, 16);
        check_eq("t4_lines", n_lines2, 2);
        check_eq("t4_line_count", line_count2, 2);
        check_eq("t4_overflow", overflow2, 1);
        check_eq("t4_in_ready", in_ready2, 0);
        flush2 = 1'b1;
        tick(1);
        flush2 = 1'b0;
        tick(4);
        check_eq("t4_flush_done", n_done2, 1);
        check_eq("t4_no_extra_line", n_lines2, 2);
        check_eq("t4_still_blocked", in_ready2, 0);

        // T5: misrouted tuple is flagged but still packed.
        do_reset();
        check_eq("t5_misroute_rst", misroute, 0);
        send(64'hDEAD, 32'h6000_0000);
        tick(1);
        check_eq("t5_misroute", misroute, 1);
        send_run(64'h701, 7);
        tick(4);
        check_eq("t5_misroute_sticky", misroute, 1);
        exp_line = mk_line(64'h700, 8);
        exp_line[63:0] = 64'hDEAD;
        check_line("t5_l0", 0, exp_line, BASE, mk_mask(8), 1'b0);

        // T6: reset discards a pending line and a partial line.
        do_reset();
        out_ready = 1'b0;
        send_run(64'h400, 8);
        check_eq("t6_pending", out_valid, 1);
        reset = 1'b1;
        tick(1);
        check_eq("t6_in_ready", in_ready, 1);
        check_eq("t6_out_valid", out_valid, 0);
        check_eq("t6_out_line", out_line, 0);
        check_eq("t6_out_addr", out_addr, 0);
        check_eq("t6_out_mask", out_mask, 0);
        check_eq("t6_flags", {out_last, flush_done, overflow, misroute}, 0);
        check_eq("t6_line_count", line_count, 0);
        reset = 1'b0;
        out_ready = 1'b1;
        send_run(64'h410, 5);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        send_run(64'h500, 8);
        tick(4);
        check_eq("t6_nlines", cap_line.size(), 1);
        check_line("t6_l0", 0, mk_line(64'h500, 8), BASE, mk_mask(8), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
